// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined integer ALU with bypass capture and stage-2 self-forwarding
module alu_pipe #(
    parameter int DATA_W     = 32,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 6,
    parameter int NUM_BYPASS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_op,
    input  logic [DATA_W-1:0]            in_src0,
    input  logic [DATA_W-1:0]            in_src1,
    input  logic [PREG_W-1:0]            in_src0_tag,
    input  logic [PREG_W-1:0]            in_src1_tag,
    input  logic                         in_src0_re,
    input  logic                         in_src1_re,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [PREG_W-1:0]            in_dst,
    input  logic                         in_dst_we,
    input  logic [ROB_W-1:0]             in_rob_id,
    input  logic [NUM_BYPASS-1:0]        byp_valid,
    input  logic [NUM_BYPASS*PREG_W-1:0] byp_tag,
    input  logic [NUM_BYPASS*DATA_W-1:0] byp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [PREG_W-1:0]            out_dst,
    output logic                         out_we,
    output logic [ROB_W-1:0]             out_rob_id,
    output logic                         out_ovf
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOR  = 5'd9;
    localparam logic [4:0] OP_LUI  = 5'd10;
    localparam logic [4:0] OP_SLL  = 5'd11;
    localparam logic [4:0] OP_SRL  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13;
    localparam logic [4:0] OP_CLZ  = 5'd14;
    localparam logic [4:0] OP_CLO  = 5'd15;
    localparam logic [4:0] OP_MOVE = 5'd16;

    function automatic logic [DATA_W-1:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] n;
        logic              done;
        n    = '0;
        done = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!done && !v[i]) n = n + ONE;
            else done = 1'b1;
        end
        return n;
    endfunction

    logic                s1_valid;
    logic [4:0]          s1_op;
    logic [DATA_W-1:0]   s1_a, s1_b;
    logic [PREG_W-1:0]   s1_tag0, s1_tag1, s1_dst;
    logic                s1_re0, s1_re1, s1_we;
    logic [ROB_W-1:0]    s1_rob;

    logic                s1_advance;
    logic [DATA_W-1:0]   cap0, cap1;
    logic [DATA_W-1:0]   op_a, op_b, addend, sum, res;
    logic                is_sub, ovf_raw, ovf;
    logic [SH_W-1:0]     shamt;

    // S2 drains on out_ready; S1 may move whenever S2 is empty or draining.
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // Walk channels from the top down so the lowest matching index wins.
    always_comb begin
        cap0 = in_src0;
        cap1 = in_src1;
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (in_src0_re && byp_valid[i] && byp_tag[i*PREG_W +: PREG_W] == in_src0_tag)
                cap0 = byp_data[i*DATA_W +: DATA_W];
            if (in_src1_re && byp_valid[i] && byp_tag[i*PREG_W +: PREG_W] == in_src1_tag)
                cap1 = byp_data[i*DATA_W +: DATA_W];
        end
        if (!in_src1_re) cap1 = in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag0  <= '0;
            s1_tag1  <= '0;
            s1_re0   <= 1'b0;
            s1_re1   <= 1'b0;
            s1_dst   <= '0;
            s1_we    <= 1'b0;
            s1_rob   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_a    <= cap0;
                s1_b    <= cap1;
                s1_tag0 <= in_src0_tag;
                s1_tag1 <= in_src1_tag;
                s1_re0  <= in_src0_re;
                s1_re1  <= in_src1_re;
                s1_dst  <= in_dst;
                s1_we   <= in_dst_we;
                s1_rob  <= in_rob_id;
            end
        end
    end

    // The S2 result overrides whatever S1 captured, so dependent ops can issue back-to-back.
    assign op_a = (out_valid && out_we && s1_re0 && out_dst == s1_tag0) ? out_data : s1_a;
    assign op_b = (out_valid && out_we && s1_re1 && out_dst == s1_tag1) ? out_data : s1_b;

    always_comb begin
        is_sub  = (s1_op == OP_SUB) || (s1_op == OP_SUBU) || (s1_op == OP_SLT);
        addend  = is_sub ? ~op_b : op_b;
        sum     = op_a + addend + (is_sub ? ONE : '0);
        ovf_raw = (op_a[DATA_W-1] == addend[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
        shamt   = op_a[SH_W-1:0];
        res     = '0;
        ovf     = 1'b0;
        case (s1_op)
            OP_ADD:  begin res = sum; ovf = ovf_raw; end
            OP_ADDU: res = sum;
            OP_SUB:  begin res = sum; ovf = ovf_raw; end
            OP_SUBU: res = sum;
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf_raw};
            OP_SLTU: res = {{(DATA_W-1){1'b0}}, op_a < op_b};
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_NOR:  res = ~(op_a | op_b);
            OP_LUI:  res = op_b << 16;
            OP_SLL:  res = op_b << shamt;
            OP_SRL:  res = op_b >> shamt;
            OP_SRA:  res = $signed(op_b) >>> shamt;
            OP_CLZ:  res = lead_zeros(op_a);
            OP_CLO:  res = lead_zeros(~op_a);
            OP_MOVE: res = op_a;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_dst    <= '0;
            out_we     <= 1'b0;
            out_rob_id <= '0;
            out_ovf    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= res;
                out_dst    <= s1_dst;
                out_we     <= s1_we && !ovf;
                out_rob_id <= s1_rob;
                out_ovf    <= ovf;
            end
        end
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined integer ALU for the integer issue ports. It accepts one micro-op per cycle over a valid/ready handshake and forwards operands from N external bypass channels at capture. It also forwards its own stage-2 result back into stage 1 so that dependent micro-ops can issue back-to-back. It reports signed overflow, supports backpressure from writeback and flushes on misprediction.

## Interface
- DATA_W, 32: operand/result width; power of two, ≥16
- PREG_W, 6: physical register tag width
- ROB_W, 6: ROB id width
- NUM_BYPASS, 2: external bypass channels
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight and presented micro-ops
- in_valid / in_ready  in / out  1  issue handshake; transfer when both high
- in_op  in  5  operation code (below)
- in_src0, in_src1  in  DATA_W  register-file operand data
- in_src0_tag, in_src1_tag  in  PREG_W  physical source tags
- in_src0_re, in_src1_re  in  1  source is a register (forwarding allowed)
- in_imm  in  DATA_W  immediate; replaces src1 when in_src1_re=0
- in_dst  in  PREG_W; in_dst_we  in  1; in_rob_id  in  ROB_W
- byp_valid  in  NUM_BYPASS  bypass channel valid
- byp_tag  in  NUM_BYPASS*PREG_W; byp_data  in  NUM_BYPASS*DATA_W  (channel i at slice i)
- out_valid / out_ready  out / in  1  writeback handshake
- out_data  out  DATA_W; out_dst  out  PREG_W; out_we  out  1; out_rob_id  out  ROB_W
- out_ovf  out  1  signed overflow; ROB raises the exception

## Operation
- Opcodes: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 SLT, 5 SLTU, 6 AND, 7 OR, 8 XOR, 9 NOR, 10 LUI, 11 SLL, 12 SRL, 13 SRA, 14 CLZ, 15 CLO, 16 MOVE. Codes 17–31 give result 0 and no overflow.
- Operand select at capture: if srcN_re=1 and some channel i has byp_valid[i] && byp_tag[i]==srcN_tag, use byp_data[i]. The lowest index wins. Otherwise use in_srcN. If in_src1_re=0, src1 = in_imm with no forwarding.
- S1 register holds op, operands, tags, re bits, dst, we, rob_id.
- Self-forward at S1 compute: if S2 is valid, s2_we=1, s2_dst==S1 srcN_tag and srcN_re=1, replace the captured operand with s2_data. This takes priority over the captured value.
- Arithmetic is modulo 2^DATA_W. SUB/SUBU/SLT compute src0 + ~src1 + 1.
- SLT compares signed and SLTU compares unsigned; the result is 0 or 1, zero-extended.
- Shifts: amount = src0[log2(DATA_W)-1:0] and the shifted value is src1. SRA sign-fills.
- LUI = src1 << 16. MOVE = src0.
- CLZ/CLO count leading 0s/1s of src0, range 0..DATA_W; all-zero gives DATA_W for CLZ.
- Overflow, for ADD and SUB only: operand signs equal and sum sign differs, using the effective addend after complementing. When overflow occurs, out_ovf=1 and out_we=0, and the result is still presented.
- Stall: S2 holds when out_valid && !out_ready. S1 advances when S2 is empty or S2 is advancing. in_ready = !s1_valid || s1_advance; this is combinational from out_ready.
- Flush: at the next edge s1_valid=0 and s2_valid=0, and the input presented that cycle is not accepted. Flush overrides accept and stall.

## Timing
- Reset (async, rst_n=0): s1_valid=s2_valid=0, out_valid=0, out_data=0, out_dst=0, out_we=0, out_rob_id=0, out_ovf=0, in_ready=1 after release.
- Latency: accept at edge T gives out_valid during cycle T+1. The result is registered at S2 and out_* are direct register outputs.
- Throughput is 1 op/cycle with no bubbles when out_ready=1.
- Under a full stall, both stages hold their contents. Held S1 operands are not re-snooped from bypass; only the self-forward from S2 is re-evaluated.
- out_* stay stable while out_valid && !out_ready.
- Flush together with out_ready: the S2 entry is discarded. Downstream ignores an out_valid transfer in the flush cycle.
- Asserting rst_n mid-stall clears everything immediately.

## Test plan
- ADD 0x7FFFFFFF+1 → out_data 0x80000000, out_ovf=1, out_we=0. ADDU with the same operands → ovf=0, we=1, 2 cycles after accept.
- Back-to-back: ADDU p5=3+4 then ADDU p6=p5+1 on consecutive cycles → outputs 7 then 8 on consecutive cycles via self-forward.
- Bypass priority: channel 0 and channel 1 both match src0_tag with data 0xA and 0xB → channel 0 value 0xA used. With in_src0_re=0, the register value is used.
- Backpressure: 3 ops issued with out_ready=0 for 4 cycles → in_ready falls after 2 accepts and out_* stay stable. After release, the 3 results appear in order with no loss or duplication.
- Flush: 2 ops in flight plus in_valid asserted, flush=1 → next cycle out_valid=0 and the in-cycle op is never output.
- Count/shift: CLZ 0 → 32; CLO 0xFFFFFFFF → 32; SRA 0x80000000 by 4 → 0xF8000000; SLT -1<1 → 1; SLTU → 0.
